// File: rtl/crt_sync_ctrl.sv
// CRT sync timing tracker: measures line and frame lengths and locks onto stable video timing.
// Define CRT_SYNC_CTRL_TIMEOUT_EN to drop lock when VSYNC stays absent for 511 lines.
module crt_sync_ctrl #(
  parameter int LOCK_FRAMES = 4,
  parameter int FRAME_TOL   = 2
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CE_4,
  input  logic        HSYNC_I,
  input  logic        VSYNC_I,
  output logic        RESYNC,
  output logic        LOCKED,
  output logic [10:0] LINE_LEN,
  output logic [8:0]  FRAME_LINES,
  output logic        MODE_50,
  output logic [1:0]  STATE
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOST    = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          hs_q_reg, vs_q_reg;
  logic [10:0]   hcnt_reg;
  logic [8:0]    vcnt_reg;
  logic [1:0]    hs_after_reg;
  logic [10:0]   frame_line_reg;
  logic [MW-1:0] match_reg, match_next;
  logic          miss_reg, miss_next;
  logic [8:0]    prev_reg, prev_next;
  logic [10:0]   line_len_reg, line_len_next;
  logic [8:0]    frame_lines_reg, frame_lines_next;
  logic          mode_50_reg, mode_50_next;
  logic          resync_reg, resync_next;
  logic          locked_reg, locked_next;

  logic          hs_edge, vs_edge, timeout;
  logic [10:0]   line_new;
  logic [8:0]    frame_new;

  assign hs_edge   = HSYNC_I & ~hs_q_reg;
  assign vs_edge   = VSYNC_I & ~vs_q_reg;
  assign line_new  = (hcnt_reg == 11'h7FF) ? 11'h7FF : hcnt_reg + 11'd1;
  // An HSYNC edge on the VSYNC tick still belongs to the frame being closed.
  assign frame_new = (hs_edge && vcnt_reg != 9'h1FF) ? vcnt_reg + 9'd1 : vcnt_reg;

`ifdef CRT_SYNC_CTRL_TIMEOUT_EN
  assign timeout = (vcnt_reg == 9'h1FF) && !vs_edge && (state_reg != ST_SEARCH);
`else
  assign timeout = 1'b0;
`endif

  function automatic logic within_tol(input logic [8:0] a, input logic [8:0] b);
    logic signed [9:0] d;
    logic [9:0]        mag;
    d   = signed'({1'b0, a}) - signed'({1'b0, b});
    mag = d[9] ? -d : d;
    return mag <= 10'(FRAME_TOL);
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hs_q_reg       <= 1'b0;
      vs_q_reg       <= 1'b0;
      hcnt_reg       <= '0;
      vcnt_reg       <= '0;
      hs_after_reg   <= '0;
      frame_line_reg <= '0;
    end else if (CE_4) begin
      hs_q_reg <= HSYNC_I;
      vs_q_reg <= VSYNC_I;
      if (hs_edge)
        hcnt_reg <= '0;
      else if (hcnt_reg != 11'h7FF)
        hcnt_reg <= hcnt_reg + 11'd1;
      if (vs_edge || timeout)
        vcnt_reg <= '0;
      else if (hs_edge && vcnt_reg != 9'h1FF)
        vcnt_reg <= vcnt_reg + 9'd1;
      // The first line after VSYNC is partial; the second is a clean length sample.
      if (vs_edge)
        hs_after_reg <= '0;
      else if (hs_edge && hs_after_reg != 2'd2) begin
        hs_after_reg <= hs_after_reg + 2'd1;
        if (hs_after_reg == 2'd1)
          frame_line_reg <= line_new;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg       <= ST_SEARCH;
      match_reg       <= '0;
      miss_reg        <= 1'b0;
      prev_reg        <= '0;
      line_len_reg    <= '0;
      frame_lines_reg <= '0;
      mode_50_reg     <= 1'b0;
      resync_reg      <= 1'b0;
      locked_reg      <= 1'b0;
    end else begin
      state_reg       <= state_next;
      match_reg       <= match_next;
      miss_reg        <= miss_next;
      prev_reg        <= prev_next;
      line_len_reg    <= line_len_next;
      frame_lines_reg <= frame_lines_next;
      mode_50_reg     <= mode_50_next;
      resync_reg      <= resync_next;
      locked_reg      <= locked_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    match_next       = match_reg;
    miss_next        = miss_reg;
    prev_next        = prev_reg;
    line_len_next    = line_len_reg;
    frame_lines_next = frame_lines_reg;
    mode_50_next     = mode_50_reg;
    if (CE_4 && vs_edge) begin
      case (state_reg)
        ST_SEARCH: begin
          state_next = ST_MEASURE;
          match_next = '0;
          prev_next  = frame_new;
        end
        ST_MEASURE: begin
          prev_next = frame_new;
          if (within_tol(frame_new, prev_reg)) begin
            match_next = match_reg + MW'(1);
            if (int'(match_reg) + 1 >= LOCK_FRAMES - 1) begin
              state_next       = ST_LOCKED;
              frame_lines_next = frame_new;
              line_len_next    = frame_line_reg;
              mode_50_next     = (frame_new >= 9'd288);
            end
          end else begin
            match_next = '0;
          end
        end
        ST_LOCKED: begin
          if (within_tol(frame_new, frame_lines_reg)) begin
            line_len_next = frame_line_reg;
          end else begin
            state_next = ST_LOST;
            miss_next  = 1'b1;
          end
        end
        default: begin
          state_next = within_tol(frame_new, frame_lines_reg) ? ST_LOCKED : ST_SEARCH;
          miss_next  = 1'b0;
        end
      endcase
    end else if (CE_4 && timeout) begin
      case (state_reg)
        ST_LOCKED: begin
          state_next = ST_LOST;
          miss_next  = 1'b1;
        end
        ST_LOST: begin
          state_next = ST_SEARCH;
          miss_next  = 1'b0;
        end
        ST_MEASURE: begin
          state_next = ST_SEARCH;
          match_next = '0;
        end
        default: ;
      endcase
    end
    resync_next = (state_next == ST_LOCKED) || (state_next == ST_LOST);
    locked_next = (state_next == ST_LOCKED);
  end

  assign RESYNC      = resync_reg;
  assign LOCKED      = locked_reg;
  assign LINE_LEN    = line_len_reg;
  assign FRAME_LINES = frame_lines_reg;
  assign MODE_50     = mode_50_reg;
  assign STATE       = state_reg;

endmodule

// File: doc/crt_sync_ctrl.md
CRT_SYNC_CTRL -- requirements
Module: crt_sync_ctrl

Interface
REQ-001 SHALL have parameter LOCK_FRAMES, default 4: consecutive matching frames required to enter LOCKED.
REQ-002 SHALL have parameter FRAME_TOL, default 2: maximum |frame_meas - previous frame_meas| in lines that still counts as a match.
REQ-003 SHALL have ports; one clock, reset asynchronous active-low:
  CLK  in  1  system clock
  RESET_N  in  1  asynchronous active-low reset
  CE_4  in  1  4 MHz clock enable; all logic advances only when CE_4=1
  HSYNC_I  in  1  raw horizontal sync
  VSYNC_I  in  1  raw vertical sync
  RESYNC  out  1  resync-mode enable for the downstream CRT sync filter
  LOCKED  out  1  sync timing stable
  LINE_LEN  out  11  CE_4 ticks per line, latched
  FRAME_LINES  out  9  lines per frame, latched
  MODE_50  out  1  FRAME_LINES >= 288
  STATE  out  2  current FSM state, for debug

Function
REQ-004 SHALL detect rising edges of HSYNC_I and VSYNC_I by comparing each against its value registered on the previous CE_4 tick.
REQ-005 SHALL use an 11-bit tick counter hcnt that increments each CE_4 tick and saturates at 2047; on an HSYNC edge, line_meas <= min(hcnt+1, 2047) and hcnt <= 0. Edges 256 ticks apart give line_meas=256.
REQ-006 SHALL use a 9-bit line counter vcnt that increments on each HSYNC edge and saturates at 511; on a VSYNC edge, frame_meas <= min(vcnt+inc, 511) and vcnt <= 0. inc=1 when an HSYNC edge falls on the same tick, else 0.
REQ-007 SHALL capture line_meas from the 2nd HSYNC edge after each VSYNC edge as frame_line.
REQ-008 SHALL implement FSM states SEARCH=0, MEASURE=1, LOCKED=2, LOST=3; STATE SHALL reflect the current state.
REQ-009 SEARCH: on a VSYNC edge, go to MEASURE with match=0 and store frame_meas as prev.
REQ-010 MEASURE: on each VSYNC edge, increment match if |frame_meas-prev| <= FRAME_TOL, else clear match to 0; prev <= frame_meas. When match reaches LOCK_FRAMES-1, go to LOCKED and latch FRAME_LINES <= frame_meas and LINE_LEN <= frame_line.
REQ-011 LOCKED: on a VSYNC edge with |frame_meas-FRAME_LINES| <= FRAME_TOL, stay and update LINE_LEN <= frame_line. On mismatch, go to LOST with miss=1; FRAME_LINES and LINE_LEN are held.
REQ-012 LOST: on a matching VSYNC edge, return to LOCKED with miss=0. On a second consecutive mismatch, go to SEARCH.
REQ-013 RESYNC SHALL be 1 in LOCKED and LOST and 0 in SEARCH and MEASURE; LOCKED SHALL be 1 only in state LOCKED. Both are registered outputs.
REQ-014 MODE_50 SHALL update only when FRAME_LINES is latched.
REQ-015 Frame comparison SHALL use 10-bit signed subtraction; no wrap-around.
REQ-016 Outputs SHALL change only on CE_4 ticks; they lag the VSYNC edge tick by one CE_4 tick.

Reset
REQ-017 RESET_N=0 SHALL asynchronously force state SEARCH; hcnt, vcnt, match, miss, prev, RESYNC, LOCKED, LINE_LEN, FRAME_LINES and MODE_50 all to 0; registered sync copies to 0.
REQ-018 Reset asserted mid-frame SHALL discard all partial measurements; after release, the first VSYNC edge is treated as in SEARCH.

Configuration
REQ-019 Macro CRT_SYNC_CTRL_TIMEOUT_EN:
  - Defined: vcnt reaching 511 in LOCKED goes to LOST. In LOST it goes to SEARCH. In MEASURE it goes to SEARCH. vcnt then restarts at 0.
  - Undefined: there is no timeout; only VSYNC-edge comparisons change state.

Verification
REQ-020 Reset, then HSYNC every 256 ticks and VSYNC every 312 lines, 5 frames -> LOCKED=1 and RESYNC=1 after the 4th VSYNC edge; FRAME_LINES=312, LINE_LEN=256, MODE_50=1.
REQ-021 Locked at 312, then one frame of 300 lines followed by 312 -> STATE goes 2 -> 3 -> 2; FRAME_LINES stays 312 throughout.
REQ-022 Locked at 312, then two consecutive 300-line frames -> STATE=0, RESYNC=0, LOCKED=0.
REQ-023 Frame lengths alternating 312/313 (jitter within FRAME_TOL) -> locks and stays LOCKED; 262-line frames -> MODE_50=0.
REQ-024 With CRT_SYNC_CTRL_TIMEOUT_EN defined, locked, then VSYNC removed -> LOST after 511 lines and SEARCH after a further 511; without the macro, the state stays LOCKED.
REQ-025 RESET_N pulsed low mid-frame while LOCKED -> all outputs 0 immediately, regardless of CE_4.
